// File: rtl/freq_div_ctrl_pkg.sv
// Shared types and helpers for the programmable duty-cycle clock divider.
package freq_div_ctrl_pkg;

    localparam int unsigned CFG_ARG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    // A config is legal when the period is at least 2 and the high time leaves at least one low cycle.
    function automatic logic cfg_legal(input logic [CFG_ARG_W-1:0] div,
                                       input logic [CFG_ARG_W-1:0] high);
        return (div >= CFG_ARG_W'(2)) && (high >= CFG_ARG_W'(1)) && (high < div);
    endfunction

endpackage

// File: rtl/freq_div_phase_cnt.sv
// Phase counter with wrap and duty compare; all outputs describe the upcoming cycle and are flop-driven.
module freq_div_phase_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_next,
    input  logic         restart,
    input  logic [W-1:0] div_next,
    input  logic [W-1:0] high_next,
    output logic         div_clk,
    output logic         period_end
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    // Next phase: hold at 0 when stopped or restarting, otherwise count and wrap at div-1.
    always_comb begin
        cnt_nxt = '0;
        if (en_next && !restart) begin
            if (cnt != div_next - W'(1)) begin
                cnt_nxt = cnt + W'(1);
            end
        end
    end

    // Register phase, duty output and last-cycle flag together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            div_clk    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            div_clk    <= en_next && (cnt_nxt < high_next);
            period_end <= en_next && (cnt_nxt == div_next - W'(1));
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable clock divider: config handshake, glitch-free config swap and stop at period boundaries.
module freq_div_ctrl
    import freq_div_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cfg_valid,
    input  logic [W-1:0] i_cfg_div,
    input  logic [W-1:0] i_cfg_high,
    output logic         o_cfg_ready,
    input  logic         i_stop,
    output logic         o_div_clk,
    output logic         o_cfg_err,
    output logic         o_active,
    output logic         o_period_end,
    output logic [W-1:0] o_cur_div,
    output logic [W-1:0] o_cur_high
);

    state_e       state, state_nxt;
    logic         stop_q, stop_nxt;
    logic [W-1:0] pend_div_q, pend_div_nxt;
    logic [W-1:0] pend_high_q, pend_high_nxt;
    logic [W-1:0] cur_div_nxt, cur_high_nxt;
    logic         cfg_err_nxt;
    logic         restart;
    logic         xfer;
    logic         legal;
    logic         stop_eff;

    // Ready is forced low during reset so nothing is accepted while the block is being cleared.
    assign o_cfg_ready = !i_rst && ((state == ST_IDLE) || ((state == ST_RUN) && !stop_q));
    assign xfer        = i_cfg_valid && o_cfg_ready;
    assign legal       = cfg_legal(CFG_ARG_W'(i_cfg_div), CFG_ARG_W'(i_cfg_high));
    // A stop requested in the last cycle of a period takes effect at that same boundary.
    assign stop_eff    = stop_q || i_stop;

    // Next-state, pending-config and applied-config selection.
    always_comb begin
        state_nxt     = state;
        stop_nxt      = stop_q;
        pend_div_nxt  = pend_div_q;
        pend_high_nxt = pend_high_q;
        cur_div_nxt   = o_cur_div;
        cur_high_nxt  = o_cur_high;
        restart       = 1'b0;
        cfg_err_nxt   = xfer && !legal;

        unique case (state)
            ST_IDLE: begin
                if (xfer && legal) begin
                    state_nxt    = ST_RUN;
                    cur_div_nxt  = i_cfg_div;
                    cur_high_nxt = i_cfg_high;
                    restart      = 1'b1;
                end
            end
            ST_RUN: begin
                if (o_period_end) begin
                    if (stop_eff) begin
                        state_nxt = ST_IDLE;
                        stop_nxt  = 1'b0;
                    end else if (xfer && legal) begin
                        cur_div_nxt  = i_cfg_div;
                        cur_high_nxt = i_cfg_high;
                        restart      = 1'b1;
                    end
                end else begin
                    stop_nxt = stop_eff;
                    if (xfer && legal) begin
                        state_nxt     = ST_PEND;
                        pend_div_nxt  = i_cfg_div;
                        pend_high_nxt = i_cfg_high;
                    end
                end
            end
            ST_PEND: begin
                if (o_period_end) begin
                    if (stop_eff) begin
                        state_nxt = ST_IDLE;
                        stop_nxt  = 1'b0;
                    end else begin
                        state_nxt    = ST_RUN;
                        cur_div_nxt  = pend_div_q;
                        cur_high_nxt = pend_high_q;
                        restart      = 1'b1;
                    end
                    pend_div_nxt  = '0;
                    pend_high_nxt = '0;
                end else begin
                    stop_nxt = stop_eff;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state and registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            stop_q      <= 1'b0;
            pend_div_q  <= '0;
            pend_high_q <= '0;
            o_cur_div   <= '0;
            o_cur_high  <= '0;
            o_cfg_err   <= 1'b0;
            o_active    <= 1'b0;
        end else begin
            state       <= state_nxt;
            stop_q      <= stop_nxt;
            pend_div_q  <= pend_div_nxt;
            pend_high_q <= pend_high_nxt;
            o_cur_div   <= cur_div_nxt;
            o_cur_high  <= cur_high_nxt;
            o_cfg_err   <= cfg_err_nxt;
            o_active    <= (state_nxt != ST_IDLE);
        end
    end

    freq_div_phase_cnt #(.W(W)) u_phase_cnt (
        .clk        (i_clk),
        .rst        (i_rst),
        .en_next    (state_nxt != ST_IDLE),
        .restart    (restart),
        .div_next   (cur_div_nxt),
        .high_next  (cur_high_nxt),
        .div_clk    (o_div_clk),
        .period_end (o_period_end)
    );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: a cycle-level reference model queues expected outputs, a monitor compares them.
module tb_freq_div_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         i_rst;
    logic         i_cfg_valid;
    logic [W-1:0] i_cfg_div;
    logic [W-1:0] i_cfg_high;
    logic         o_cfg_ready;
    logic         i_stop;
    logic         o_div_clk;
    logic         o_cfg_err;
    logic         o_active;
    logic         o_period_end;
    logic [W-1:0] o_cur_div;
    logic [W-1:0] o_cur_high;

    freq_div_ctrl #(.W(W)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_div    (i_cfg_div),
        .i_cfg_high   (i_cfg_high),
        .o_cfg_ready  (o_cfg_ready),
        .i_stop       (i_stop),
        .o_div_clk    (o_div_clk),
        .o_cfg_err    (o_cfg_err),
        .o_active     (o_active),
        .o_period_end (o_period_end),
        .o_cur_div    (o_cur_div),
        .o_cur_high   (o_cur_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ready;
        int dclk;
        int err;
        int act;
        int pe;
        int cdiv;
        int chigh;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_no   = 0;

    // Reference model: running flag, position in the period, applied and waiting configs, stop request.
    bit m_run = 0;
    int m_phase = 0;
    int m_div = 0;
    int m_high = 0;
    bit m_has_pend = 0;
    int m_pdiv = 0;
    int m_phigh = 0;
    bit m_stop = 0;
    bit m_err = 0;

    task automatic chk(input string nm, input int c, input logic [31:0] got, input int want);
        n_checks++;
        if (got !== 32'(want)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, c, got, want);
        end
    endtask

    // One cycle: drive inputs, queue what the outputs must be this cycle, then advance the model over the edge.
    task automatic cyc(input bit rst, input bit v, input int d, input int h, input bit s);
        exp_t e;
        bit   rdy, xfer, legal, at_end, stop_now;
        int   dd, hh;
        dd = d % 256;
        hh = h % 256;
        i_rst       = rst;
        i_cfg_valid = v;
        i_cfg_div   = W'(dd);
        i_cfg_high  = W'(hh);
        i_stop      = s;

        rdy     = !rst && (!m_run || (!m_has_pend && !m_stop));
        e.cyc   = cyc_no;
        e.ready = rdy ? 1 : 0;
        e.dclk  = (m_run && m_phase < m_high) ? 1 : 0;
        e.pe    = (m_run && m_phase == m_div - 1) ? 1 : 0;
        e.act   = m_run ? 1 : 0;
        e.err   = m_err ? 1 : 0;
        e.cdiv  = m_div;
        e.chigh = m_high;
        exp_q.push_back(e);

        if (rst) begin
            m_run = 0; m_phase = 0; m_div = 0; m_high = 0;
            m_has_pend = 0; m_stop = 0; m_err = 0;
        end else begin
            xfer  = v && rdy;
            legal = (dd >= 2) && (hh >= 1) && (hh < dd);
            m_err = xfer && !legal;
            if (!m_run) begin
                if (xfer && legal) begin
                    m_run = 1; m_phase = 0; m_div = dd; m_high = hh;
                end
            end else begin
                at_end   = (m_phase == m_div - 1);
                stop_now = m_stop || s;
                if (xfer && legal) begin
                    m_has_pend = 1; m_pdiv = dd; m_phigh = hh;
                end
                if (at_end) begin
                    m_phase = 0;
                    if (stop_now) begin
                        m_run = 0; m_has_pend = 0; m_stop = 0;
                    end else if (m_has_pend) begin
                        m_div = m_pdiv; m_high = m_phigh; m_has_pend = 0;
                    end
                end else begin
                    m_phase++;
                    m_stop = stop_now;
                end
            end
        end

        @(posedge clk);
        #2;
        cyc_no++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Idle until the model reaches the requested phase, bounded.
    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (m_phase != ph && k < 64) begin
            cyc(0, 0, 0, 0, 0);
            k++;
        end
    endtask

    // Monitor: compare all outputs away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cfg_ready",  e.cyc, 32'(o_cfg_ready),  e.ready);
            chk("div_clk",    e.cyc, 32'(o_div_clk),    e.dclk);
            chk("cfg_err",    e.cyc, 32'(o_cfg_err),    e.err);
            chk("active",     e.cyc, 32'(o_active),     e.act);
            chk("period_end", e.cyc, 32'(o_period_end), e.pe);
            chk("cur_div",    e.cyc, 32'(o_cur_div),    e.cdiv);
            chk("cur_high",   e.cyc, 32'(o_cur_high),   e.chigh);
        end
    end

    initial begin
        i_rst = 1'b1; i_cfg_valid = 1'b0; i_cfg_div = '0; i_cfg_high = '0; i_stop = 1'b0;
        @(posedge clk);
        #2;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 4, 2, 1);
        idle(2);

        // 4/2 steady run
        cyc(0, 1, 4, 2, 0);
        idle(10);

        // Swap to 6/1 accepted at phase 1
        wait_phase(1);
        cyc(0, 1, 6, 1, 0);
        idle(14);

        // Illegal offers while running
        cyc(0, 1, 4, 4, 0);
        cyc(0, 1, 1, 0, 0);
        idle(3);

        // 5/3 then stop at phase 0
        wait_phase(5);
        cyc(0, 1, 5, 3, 0);
        idle(2);
        wait_phase(0);
        cyc(0, 0, 0, 0, 1);
        idle(8);

        // Reset mid-period, then 2/1
        cyc(0, 1, 4, 2, 0);
        wait_phase(1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 2, 1, 0);
        idle(6);

        // Illegal offers in idle after a stop
        cyc(0, 0, 0, 0, 1);
        idle(3);
        cyc(0, 1, 3, 0, 0);
        cyc(0, 1, 0, 0, 0);
        idle(2);

        // Config and stop together: stop wins, config dropped
        cyc(0, 1, 3, 1, 0);
        wait_phase(0);
        cyc(0, 1, 7, 3, 1);
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)),
                ($urandom_range(0, 24) == 0));
        end
        idle(2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 Parameter: W, default 8, width of the divide-ratio and high-time fields.
REQ-002 Ports (clock and reset first):
- i_clk  input  1  single clock, driven by the ring-oscillator clock generator.
- i_rst  input  1  reset, synchronous, active-high.
- i_cfg_valid  input  1  configuration request valid.
- i_cfg_div  input  W  requested period in i_clk cycles.
- i_cfg_high  input  W  requested high time in i_clk cycles.
- o_cfg_ready  output  1  configuration can be accepted this cycle.
- i_stop  input  1  one-cycle stop request.
- o_div_clk  output  1  divided clock with programmed duty cycle, flop-driven.
- o_cfg_err  output  1  one-cycle pulse: offered config rejected.
- o_active  output  1  divider running (RUN or PEND).
- o_period_end  output  1  one-cycle pulse on the last cycle of each period.
- o_cur_div, o_cur_high  output  W each  currently applied configuration.
REQ-003 The block SHALL use one clock, i_clk; reset i_rst SHALL be synchronous and active-high.

Function
REQ-004 A transfer SHALL occur when i_cfg_valid and o_cfg_ready are both high on a rising edge of i_clk.
REQ-005 Legal config: div >= 2 and 1 <= high <= div-1; otherwise the config SHALL be rejected: o_cfg_err high next cycle for one cycle, with no state or counter change.
REQ-006 FSM states SHALL be IDLE, RUN, and PEND (new config held, waiting for period end).
REQ-007 o_cfg_ready SHALL be 1 in IDLE, and 1 in RUN unless a stop is pending; it SHALL be 0 in PEND.
REQ-008 IDLE, legal transfer at cycle t: RUN at t+1 with phase counter cnt = 0, o_div_clk = 1 at t+1.
REQ-009 In RUN/PEND, cnt SHALL count 0..div-1 and wrap to 0; o_div_clk SHALL be 1 when cnt < high, else 0.
REQ-010 o_period_end SHALL be 1 in the cycle cnt == div-1.
REQ-011 RUN, legal transfer: go to PEND; the new config SHALL be held until the next period end, then applied with cnt = 0, returning to RUN. This is glitch-free: no truncated period.
REQ-012 i_stop in IDLE SHALL be ignored.
REQ-013 i_stop in RUN/PEND SHALL set a stop-pending flag. At the next period end: go to IDLE, discard any pending config, hold o_div_clk at 0.
REQ-014 A transfer and i_stop in the same RUN cycle SHALL both be registered. The stop SHALL win at period end and the config SHALL be discarded.
REQ-015 o_active SHALL be 1 exactly in RUN and PEND.
REQ-016 o_cur_div and o_cur_high SHALL update in the cycle the new config takes effect.
REQ-017 Arithmetic: all comparisons SHALL be unsigned W-bit; cnt SHALL be W bits and never exceed div-1.

Reset
REQ-018 While i_rst is high: state IDLE, cnt 0, stop flag 0, pending config cleared.
REQ-019 Reset values: o_div_clk 0, o_cfg_err 0, o_active 0, o_period_end 0, o_cur_div 0, o_cur_high 0.
REQ-020 Reset asserted mid-period SHALL abort the period immediately, with no completion of the current high/low phase.
REQ-021 o_cfg_ready SHALL be 0 during reset and SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-022 A shared package SHALL hold the state enum (IDLE, RUN, PEND) and the legality-check function.
REQ-023 One sub-module, freq_div_phase_cnt, SHALL contain cnt, its wrap, and the duty compare; the FSM and handshake SHALL stay in the top.

Verification
REQ-024 Reset, then config div=4, high=2 -> o_div_clk 1,1,0,0 repeating; o_period_end every 4th cycle, coincident with the second 0.
REQ-025 Running 4/2, accept div=6, high=1 at cnt=1 -> current period completes as 1,1,0,0; then 1,0,0,0,0,0; o_cfg_ready 0 in between.
REQ-026 Offer div=4, high=4, then div=1, high=0 -> o_cfg_err pulses once each; output and state unchanged.
REQ-027 Running 5/3, i_stop at cnt=0 -> one full period 1,1,1,0,0 finishes, then IDLE with o_div_clk 0 and o_active 0.
REQ-028 i_rst asserted at cnt=1 of a 4/2 run -> next cycle all outputs at reset values; a following 2/1 config yields 1,0 repeating.
REQ-029 Simultaneous legal config and i_stop in RUN -> stop at period end; new config never applied; o_cur_div unchanged.
